// File: rtl/out_channel_pkg.sv
// Shared types and defaults for the interpreter's out-instruction path.
package out_channel_pkg;

   localparam int MEMORY_ELEMENT_WIDTH = 12;
   localparam int unsigned N_OUT       = 16;
   localparam int COUNT_WIDTH          = $clog2(N_OUT) + 1;

   typedef logic [MEMORY_ELEMENT_WIDTH-1:0] word_t;
   typedef logic [COUNT_WIDTH-1:0]          count_t;

endpackage

// File: rtl/out_channel.sv
// Buffered sink for the out instruction: circular FIFO with running word
// count, modular checksum and a sticky overflow flag for dropped words.
module out_channel
   import out_channel_pkg::*;
#(
   parameter int          MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
   parameter int unsigned NOut               = N_OUT
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [MemoryElementWidth-1:0] in_data,
   output logic                          out_valid,
   output logic [MemoryElementWidth-1:0] out_data,
   input  logic                          out_ready,
   output logic [$clog2(NOut):0]         count,
   output logic                          overflow,
   output logic [MemoryElementWidth-1:0] checksum,
   output logic [31:0]                   words
);

   localparam int PW = $clog2(NOut);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(NOut);

   logic [MemoryElementWidth-1:0] mem [NOut];
   logic [PW-1:0]                 rd;
   logic [PW-1:0]                 wr;
   logic                          pop;
   logic                          push;
   logic                          drop;

   // Handshake decode; a pop frees a slot for a same-cycle push when full.
   always_comb begin
      out_valid = (count != '0);
      pop       = out_valid && out_ready;
      push      = in_valid && ((count < FULL) || pop);
      drop      = in_valid && (count == FULL) && !pop;
      out_data  = mem[rd];
   end

   // Storage, pointers, occupancy and accepted-word statistics.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NOut; i++) begin
            mem[i] <= '0;
         end
         rd       <= '0;
         wr       <= '0;
         count    <= '0;
         overflow <= 1'b0;
         checksum <= '0;
         words    <= '0;
      end else begin
         if (push) begin
            mem[wr]  <= in_data;
            wr       <= wr + PW'(1);
            checksum <= checksum + in_data;
            words    <= words + 32'd1;
         end
         if (pop) begin
            rd <= rd + PW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_out_channel.sv
// Directed self-checking bench for out_channel.
module tb_out_channel;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic [11:0] in_data;
   logic        out_valid;
   logic [11:0] out_data;
   logic        out_ready;
   logic [4:0]  count;
   logic        overflow;
   logic [11:0] checksum;
   logic [31:0] words;

   int checks;
   int passed;
   int fails;

   logic [11:0] got [$];

   out_channel #(.MemoryElementWidth(12), .NOut(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow),
      .checksum  (checksum),
      .words     (words)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic push_word(input logic [11:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_data"},  32'(out_data),  0);
      check({tag, "_count"},     32'(count),     0);
      check({tag, "_overflow"},  32'(overflow),  0);
      check({tag, "_checksum"},  32'(checksum),  0);
      check({tag, "_words"},     words,          0);
   endtask

   initial begin
      logic [11:0] exp4 [4];
      int pushed;
      int cyc;

      checks    = 0;
      passed    = 0;
      fails     = 0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;

      // Reset state
      do_reset();
      check_reset_state("rst");

      // Push 0, 1, 99, 2 with no consumer
      push_word(12'd0);
      check("lat_valid", 32'(out_valid), 1);
      check("lat_count", 32'(count), 1);
      push_word(12'd1);
      push_word(12'd99);
      push_word(12'd2);
      check("fill4_count", 32'(count), 4);
      check("fill4_checksum", 32'(checksum), 102);
      check("fill4_words", words, 4);
      check("fill4_head", 32'(out_data), 0);

      // Drain in order
      exp4[0] = 12'd0; exp4[1] = 12'd1; exp4[2] = 12'd99; exp4[3] = 12'd2;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain4_valid%0d", i), 32'(out_valid), 1);
         check($sformatf("drain4_data%0d", i), 32'(out_data), 32'(exp4[i]));
         tick();
      end
      out_ready = 1'b0;
      check("drain4_empty_valid", 32'(out_valid), 0);
      check("drain4_empty_count", 32'(count), 0);
      check("drain4_checksum_kept", 32'(checksum), 102);

      // Fill with 16 fives, then overflow with 7
      do_reset();
      for (int i = 0; i < 16; i++) push_word(12'd5);
      check("full_count", 32'(count), 16);
      check("full_no_ovf", 32'(overflow), 0);
      push_word(12'd7);
      check("ovf_count", 32'(count), 16);
      check("ovf_flag", 32'(overflow), 1);
      check("ovf_words", words, 16);
      check("ovf_checksum", 32'(checksum), 80);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("ovf_drain%0d", i), 32'(out_data), 5);
         tick();
      end
      out_ready = 1'b0;
      check("ovf_drained_valid", 32'(out_valid), 0);
      check("ovf_sticky", 32'(overflow), 1);

      // Full: push 9 together with a pop
      do_reset();
      for (int i = 0; i < 16; i++) push_word(12'(10 + i));
      check("fullpp_head", 32'(out_data), 10);
      in_valid  = 1'b1;
      in_data   = 12'd9;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("fullpp_count", 32'(count), 16);
      check("fullpp_ovf", 32'(overflow), 0);
      check("fullpp_words", words, 17);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("fullpp_drain%0d", i), 32'(out_data), (i < 15) ? 32'(11 + i) : 32'd9);
         tick();
      end
      out_ready = 1'b0;
      check("fullpp_empty", 32'(out_valid), 0);

      // Stream 0..39 across pointer wrap with out_ready toggling
      do_reset();
      got.delete();
      pushed = 0;
      cyc    = 0;
      while ((got.size() < 40) && (cyc < 400)) begin
         out_ready = cyc[0];
         if ((pushed < 40) && ((cyc < 24) || !cyc[0])) begin
            in_valid = 1'b1;
            in_data  = 12'(pushed);
            pushed++;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid && out_ready) got.push_back(out_data);
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("stream_drained", 32'(got.size()), 40);
      for (int i = 0; i < got.size(); i++) begin
         check($sformatf("stream_word%0d", i), 32'(got[i]), 32'(i));
      end
      check("stream_checksum", 32'(checksum), 780);
      check("stream_words", words, 40);
      check("stream_no_ovf", 32'(overflow), 0);
      check("stream_empty", 32'(out_valid), 0);

      // Empty: push with out_ready high must not fall through
      do_reset();
      in_valid  = 1'b1;
      in_data   = 12'd3;
      out_ready = 1'b1;
      check("nofall_valid_before", 32'(out_valid), 0);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("nofall_valid", 32'(out_valid), 1);
      check("nofall_data", 32'(out_data), 3);
      check("nofall_count", 32'(count), 1);

      // Reset mid-stream discards words and ignores the word presented
      push_word(12'd4);
      push_word(12'd6);
      push_word(12'd8);
      check("midrst_pre_count", 32'(count), 4);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 12'd77;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      check_reset_state("midrst");
      tick();
      check("midrst_after_count", 32'(count), 0);
      check("midrst_after_valid", 32'(out_valid), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
